// File: rtl/logic_unit_seq_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the sequential logic unit.
// The ALU top-level decoder imports the same opcode enum.
package logic_unit_seq_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Counter width for n chunks; a single-chunk unit still keeps a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logic_unit_seq_slice.sv
// Purely combinational CHUNK-bit gate array computing AND/OR/XOR/NOR.
// Reused every cycle by the sequential unit; also usable standalone.
module logic_unit_seq_slice
    import logic_unit_seq_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  op_e              i_op,
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic [CHUNK-1:0] o_y
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves o_y unassigned (no latch).
        o_y = '0;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NOR:  o_y = ~(i_a | i_b);
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: one CHUNK-bit slice per clock, LSB chunk first,
// start/busy/done handshake shared with the sequential multiplier; registered out and zero flag.
module logic_unit_seq
    import logic_unit_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int                N        = WIDTH / CHUNK;
    localparam int                CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    op_e                r_opr;
    logic               r_zacc;

    logic [CHUNK-1:0]   w_s;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_zacc_next;

    logic_unit_seq_slice #(.CHUNK(CHUNK)) u_slice (
        .i_op (r_opr),
        .i_a  (r_a[CHUNK-1:0]),
        .i_b  (r_b[CHUNK-1:0]),
        .o_y  (w_s)
    );

    // New chunk enters at the top so the LSB chunk ends up at bit 0 after N steps.
    assign w_res_next  = (WIDTH'(w_s) << (WIDTH - CHUNK)) | (r_res >> CHUNK);
    assign w_zacc_next = r_zacc & (w_s == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the synchronous reset clears the datapath registers too, so an aborted op leaves nothing behind.
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_opr   <= OP_AND;
            r_zacc  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
            zero    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= S_BUSY;
                        r_a     <= i0;
                        r_b     <= i1;
                        r_opr   <= op_e'(op);
                        r_cnt   <= '0;
                        r_zacc  <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_res  <= w_res_next;
                    r_a    <= r_a >> CHUNK;
                    r_b    <= r_b >> CHUNK;
                    r_zacc <= w_zacc_next;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        out     <= w_res_next;
                        zero    <= w_zacc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
